// File: rtl/pendulum_homing_controller.sv
// pendulum_homing_controller: homing sequencer (seek left, seek right/measure span, centre, settle, calib strobe, hand-off).
// Define ENDSTOP_DEBOUNCE_EN to add a DEBOUNCE_CYCLES stability filter after the endstop synchronisers.
module pendulum_homing_controller #(
  parameter int STEP_PERIOD     = 1400,
  parameter int MAX_TRAVEL      = 6400,
  parameter int POS_WIDTH       = 16,
  parameter int SETTLE_CYCLES   = 500000,
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 end_left_i,
  input  logic                 end_right_i,
  output logic                 step_o,
  output logic                 dir_o,
  output logic                 calib_o,
  output logic                 sim_enable_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 fault_o,
  output logic [2:0]           fault_code_o,
  output logic [POS_WIDTH-1:0] span_o,
  output logic [POS_WIDTH-1:0] center_o
);
  localparam int PER_W = $clog2(STEP_PERIOD + 1);
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(STEP_PERIOD - 1);
  localparam logic [PER_W-1:0] HIGH_MIN = PER_W'(STEP_PERIOD - STEP_PERIOD / 2);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [POS_WIDTH-1:0] MAX_CNT = POS_WIDTH'(MAX_TRAVEL);

  if (STEP_PERIOD < 4 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
    $error("pendulum_homing_controller: STEP_PERIOD must be >= 4 and DEBOUNCE_CYCLES >= 1");
  end

  typedef enum logic [2:0] {IDLE, SEEK_LEFT, SEEK_RIGHT, MOVE_CENTER, SETTLE, RUN, FAULT} state_e;

  // endstops as {right, left}
  logic [1:0] sync1_q, sync2_q, lim_s;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {end_right_i, end_left_i};
      sync2_q <= sync1_q;
    end
  end

`ifdef ENDSTOP_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  for (genvar i = 0; i < 2; i++) begin : g_db
    logic [DB_W-1:0] cnt_q;
    logic            lvl_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q <= '0;
        lvl_q <= 1'b0;
      end else if (sync2_q[i] == lvl_q) begin
        cnt_q <= '0;
      end else if (cnt_q == DB_LAST) begin
        cnt_q <= '0;
        lvl_q <= sync2_q[i];
      end else begin
        cnt_q <= cnt_q + DB_W'(1);
      end
    end
    assign lim_s[i] = lvl_q;
  end
`else
  assign lim_s = sync2_q;
`endif

  logic el_s, er_s, both_s;
  assign el_s   = lim_s[0];
  assign er_s   = lim_s[1];
  assign both_s = el_s & er_s;

  state_e                 state_q, state_d;
  logic [PER_W-1:0]       per_q, per_d;
  logic                   step_q, step_d, dir_q, dir_d, done_q, done_d;
  logic [POS_WIDTH-1:0]   cnt_q, cnt_d, span_q, span_d, center_q, center_d;
  logic [SET_W-1:0]       set_q, set_d;
  logic [2:0]             code_q, code_d;
  logic                   want_dir, go, dir_chg, fire, busy;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      per_q    <= '0;
      step_q   <= 1'b0;
      dir_q    <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      span_q   <= '0;
      center_q <= '0;
      set_q    <= '0;
      code_q   <= '0;
    end else begin
      state_q  <= state_d;
      per_q    <= per_d;
      step_q   <= step_d;
      dir_q    <= dir_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      span_q   <= span_d;
      center_q <= center_d;
      set_q    <= set_d;
      code_q   <= code_d;
    end
  end

  assign busy = state_q inside {SEEK_LEFT, SEEK_RIGHT, MOVE_CENTER, SETTLE};

  always_comb begin
    want_dir = state_q == SEEK_RIGHT;
    go = ((state_q == SEEK_LEFT) & ~el_s) | ((state_q == SEEK_RIGHT) & ~er_s)
       | ((state_q == MOVE_CENTER) & ~el_s & (cnt_q < center_q));
    // a direction flip waits for step low and restarts the period so a full gap precedes the next edge
    dir_chg = (want_dir != dir_q) & ~step_q;
    fire = go & ~both_s & (cnt_q < MAX_CNT) & (per_q == '0) & ~step_q & (want_dir == dir_q);
    per_d = (dir_chg | fire) ? PER_LAST : (per_q != '0) ? per_q - PER_W'(1) : per_q;
    step_d = fire | (step_q & (per_d >= HIGH_MIN));
    dir_d = dir_chg ? want_dir : dir_q;
    cnt_d = fire ? cnt_q + POS_WIDTH'(1) : cnt_q;
    state_d = state_q;
    code_d = code_q;
    span_d = span_q;
    center_d = center_q;
    set_d = '0;
    done_d = 1'b0;
    case (state_q)
      IDLE, RUN, FAULT: begin
        if (start_i) begin
          state_d = SEEK_LEFT;
          code_d = '0;
          cnt_d = '0;
        end else if (state_q == RUN && (el_s | er_s)) begin
          state_d = FAULT;
          code_d = 3'd4;
        end
      end
      SEEK_LEFT: begin
        if (el_s) begin
          state_d = SEEK_RIGHT;
          cnt_d = '0;
        end else if (cnt_q == MAX_CNT) begin
          state_d = FAULT;
          code_d = 3'd1;
        end
      end
      SEEK_RIGHT: begin
        if (er_s) begin
          state_d = MOVE_CENTER;
          span_d = cnt_q;
          center_d = cnt_q >> 1;
          cnt_d = '0;
        end else if (cnt_q == MAX_CNT) begin
          state_d = FAULT;
          code_d = 3'd2;
        end
      end
      MOVE_CENTER: begin
        if (el_s) begin
          state_d = FAULT;
          code_d = 3'd3;
        end else if (cnt_q == center_q && !step_q && per_q == '0 && dir_q == want_dir) begin
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        set_d = set_q + SET_W'(1);
        if (set_q == SET_LAST) begin
          state_d = RUN;
          set_d = '0;
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (busy && both_s) begin
      state_d = FAULT;
      code_d = 3'd3;
      done_d = 1'b0;
    end
  end

  always_comb begin
    step_o       = step_q;
    dir_o        = dir_q;
    calib_o      = (state_q == SETTLE) && (set_q == SET_LAST);
    sim_enable_o = state_q == RUN;
    busy_o       = busy;
    done_o       = done_q;
    fault_o      = state_q == FAULT;
    fault_code_o = code_q;
    span_o       = span_q;
    center_o     = center_q;
  end
endmodule

// File: tb/tb_pendulum_homing_controller.sv
// tb_pendulum_homing_controller: table of full homing runs plus hand sequences for both-limit, reset and RUN faults.
module tb_pendulum_homing_controller;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, el = 1'b0, er = 1'b0;
  logic step, dir, calib, sim_en, busy, done, fault, step_prev = 1'b0;
  logic [2:0] code;
  logic [15:0] span, center;
  int n_chk = 0, n_pass = 0, nl = 0, nr = 0, ncal = 0, ndone = 0;

  typedef struct {int la; int ra; int sp; int ce; int nl; int nr; int flt; int code;} vec_t;
  vec_t tbl[6];

  pendulum_homing_controller #(
    .STEP_PERIOD(4), .MAX_TRAVEL(100), .POS_WIDTH(16), .SETTLE_CYCLES(8), .DEBOUNCE_CYCLES(1024)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .end_left_i(el), .end_right_i(er),
    .step_o(step), .dir_o(dir), .calib_o(calib), .sim_enable_o(sim_en), .busy_o(busy),
    .done_o(done), .fault_o(fault), .fault_code_o(code), .span_o(span), .center_o(center)
  );

  always #5 clk = ~clk;

  // step rising edges counted per direction, plus calib/done pulses
  always @(negedge clk) begin
    if (step && !step_prev) begin
      if (dir) nr = nr + 1;
      else nl = nl + 1;
    end
    step_prev = step;
    if (calib) ncal = ncal + 1;
    if (done) ndone = ndone + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_row(input vec_t r, input int idx);
    int bl, br, bc, bd;
    bl = nl; br = nr; bc = ncal; bd = ndone;
    if (r.la == -1) begin
      el = 1'b1;
      repeat (4) tick();
    end
    pulse_start();
    if (r.la > 0) begin
      for (int k = 0; k < 3000 && nl - bl < r.la; k++) tick();
      el = 1'b1;
    end
    if (r.la != -2) begin
      for (int k = 0; k < 3000 && !dir && !fault; k++) tick();
      el = 1'b0;
      if (r.ra > 0) begin
        for (int k = 0; k < 3000 && nr - br < r.ra; k++) tick();
        er = 1'b1;
        for (int k = 0; k < 3000 && dir; k++) tick();
        er = 1'b0;
      end
    end
    for (int k = 0; k < 3000 && !fault && !sim_en; k++) tick();
    chk($sformatf("r%0d_finished", idx), int'(fault | sim_en), 1);
    repeat (8) tick();
    chk($sformatf("r%0d_span", idx), int'(span), r.sp);
    chk($sformatf("r%0d_center", idx), int'(center), r.ce);
    chk($sformatf("r%0d_left_steps", idx), nl - bl, r.nl);
    chk($sformatf("r%0d_right_steps", idx), nr - br, r.nr);
    chk($sformatf("r%0d_fault", idx), int'(fault), r.flt);
    chk($sformatf("r%0d_code", idx), int'(code), r.code);
    chk($sformatf("r%0d_sim_en", idx), int'(sim_en), 1 - r.flt);
    chk($sformatf("r%0d_busy", idx), int'(busy), 0);
    chk($sformatf("r%0d_calib", idx), ncal - bc, 1 - r.flt);
    chk($sformatf("r%0d_done", idx), ndone - bd, 1 - r.flt);
    chk($sformatf("r%0d_step_low", idx), int'(step), 0);
  endtask

  // enter SEEK_RIGHT and let a few right steps happen
  task automatic into_seek_right(output int br);
    int bl;
    bl = nl; br = nr;
    pulse_start();
    for (int k = 0; k < 3000 && nl - bl < 2; k++) tick();
    el = 1'b1;
    for (int k = 0; k < 3000 && !dir; k++) tick();
    el = 1'b0;
    for (int k = 0; k < 3000 && nr - br < 3; k++) tick();
  endtask

  initial begin
    int br;
    tbl[0] = '{10, 60, 60, 30, 40, 60, 0, 0};
    tbl[1] = '{-1, 61, 61, 30, 30, 61, 0, 0};
    tbl[2] = '{5, 1, 1, 0, 5, 1, 0, 0};
    tbl[3] = '{3, 7, 7, 3, 6, 7, 0, 0};
    tbl[4] = '{-2, -1, 7, 3, 100, 0, 1, 1};
    tbl[5] = '{4, -1, 7, 3, 4, 100, 1, 2};

    repeat (3) tick();
    chk("reset_ctrl", int'({step, dir, calib, sim_en, busy, done, fault, code}), 0);
    chk("reset_span", int'(span), 0);
    chk("reset_center", int'(center), 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) run_row(tbl[i], i);

    into_seek_right(br);
    el = 1'b1;
    er = 1'b1;
    br = nr;
    for (int k = 0; k < 3 && !fault; k++) tick();
    chk("both_fault", int'(fault), 1);
    chk("both_code", int'(code), 3);
    repeat (10) tick();
    chk("both_no_step", nr - br, 0);
    chk("both_step_low", int'(step), 0);
    el = 1'b0;
    er = 1'b0;
    repeat (4) tick();

    into_seek_right(br);
    chk("pre_rst_busy", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ctrl", int'({step, dir, calib, sim_en, busy, done, fault, code}), 0);
    chk("async_rst_span", int'(span), 0);
    chk("async_rst_center", int'(center), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_row(tbl[0], 6);

    er = 1'b1;
    tick();
    er = 1'b0;
    for (int k = 0; k < 6 && !fault; k++) tick();
    chk("run_fault", int'(fault), 1);
    chk("run_code", int'(code), 4);
    chk("run_sim_en", int'(sim_en), 0);
    pulse_start();
    chk("restart_fault", int'(fault), 0);
    chk("restart_busy", int'(busy), 1);
    chk("restart_code", int'(code), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
